// File: rtl/decide_unit.sv
// Decision responder: scans the bin's variable-state array for the lowest free
// variable, assigns it FALSE at a new decision level, or reports all-satisfied.
module decide_unit #(
  parameter int unsigned NUM_VARS  = 8,
  parameter int unsigned WIDTH_VAR = 4,
  parameter int unsigned WIDTH_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_decision_i,
  input  logic                 load_lvl_i,
  input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
  output logic                 rd_en_o,
  output logic [WIDTH_VAR-1:0] rd_addr_o,
  input  logic [1:0]           rd_value_i,
  output logic                 wr_en_o,
  output logic [WIDTH_VAR-1:0] wr_addr_o,
  output logic [1:0]           wr_value_o,
  output logic [WIDTH_LVL-1:0] wr_lvl_o,
  output logic                 done_decision_o,
  output logic                 all_c_is_sat_o,
  output logic [WIDTH_LVL-1:0] cur_lvl_o,
  output logic                 busy_o,
  output logic                 lvl_ovf_o
);

  typedef enum logic [1:0] {IDLE, SCAN, ASSIGN, DONE} state_t;

  localparam logic [WIDTH_VAR-1:0] CNT_END  = WIDTH_VAR'(NUM_VARS);
  localparam logic [WIDTH_VAR-1:0] LAST_IDX = WIDTH_VAR'(NUM_VARS - 1);

  state_t               state, state_nxt;
  logic [WIDTH_VAR-1:0] cnt;
  logic [WIDTH_VAR-1:0] pipe_idx;
  logic                 pipe_vld;
  logic                 issue;
  logic                 hit_free;
  logic                 hit_last;
  logic                 lvl_max;
  logic [WIDTH_LVL-1:0] lvl_inc;

  assign issue    = (state == SCAN) && (cnt != CNT_END);
  assign hit_free = pipe_vld && (rd_value_i == 2'b00);
  assign hit_last = pipe_vld && (pipe_idx == LAST_IDX);
  assign lvl_max  = &cur_lvl_o;
  assign lvl_inc  = lvl_max ? cur_lvl_o : cur_lvl_o + WIDTH_LVL'(1);

  assign rd_en_o         = issue;
  assign rd_addr_o       = issue ? cnt : '0;
  assign wr_en_o         = (state == ASSIGN);
  assign wr_value_o      = (state == ASSIGN) ? 2'b01 : 2'b00;
  assign done_decision_o = (state == DONE);
  assign busy_o          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_decision_i) state_nxt = SCAN;
      SCAN: begin
        if (hit_free)      state_nxt = ASSIGN;
        else if (hit_last) state_nxt = DONE;
      end
      ASSIGN:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // wr_addr_o/wr_lvl_o are captured on the SCAN->ASSIGN edge so they hold outside ASSIGN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      pipe_idx       <= '0;
      pipe_vld       <= 1'b0;
      wr_addr_o      <= '0;
      wr_lvl_o       <= '0;
      all_c_is_sat_o <= 1'b0;
      cur_lvl_o      <= '0;
      lvl_ovf_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pipe_vld <= 1'b0;
          if (start_decision_i) begin
            cnt            <= '0;
            all_c_is_sat_o <= 1'b0;
          end
          if (load_lvl_i) cur_lvl_o <= bkt_lvl_i;
        end
        SCAN: begin
          pipe_vld <= issue;
          pipe_idx <= cnt;
          if (issue) cnt <= cnt + WIDTH_VAR'(1);
          if (hit_free) begin
            wr_addr_o <= pipe_idx;
            wr_lvl_o  <= lvl_inc;
          end else if (hit_last) begin
            all_c_is_sat_o <= 1'b1;
          end
        end
        ASSIGN: begin
          cur_lvl_o <= lvl_inc;
          if (lvl_max) lvl_ovf_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
